// File: rtl/tft_timing_gen_if.sv
// ---------------------------------------------------------------------------
// tft_timing_gen_if
// Purpose : bundles the run-control input and all timing/power outputs of the
//           TFT timing generator so that they pass between blocks as one port.
// Signals : enable        run request (1 = power up and run, 0 = orderly stop)
//           tft_vdd       panel supply enable
//           tft_display   panel DISP enable
//           tft_hsync     horizontal sync, active low
//           tft_vsync     vertical sync, active low
//           tft_data_ena  active-area flag
//           x, y          current pixel position
//           new_line      1-cycle strobe at x==0
//           new_frame     1-cycle strobe at x==0 && y==0
//           frame_count   completed-frame count
//           pwr_ready     panel powered and scanning
// Modports: master = timing generator, slave = consumer (ScreenMux, pixel src).
// ---------------------------------------------------------------------------
interface tft_timing_gen_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int FCNT_W = 8
);
    logic              enable;
    logic              tft_vdd;
    logic              tft_display;
    logic              tft_hsync;
    logic              tft_vsync;
    logic              tft_data_ena;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              new_line;
    logic              new_frame;
    logic [FCNT_W-1:0] frame_count;
    logic              pwr_ready;

    modport master (
        input  enable,
        output tft_vdd, tft_display, tft_hsync, tft_vsync, tft_data_ena,
        output x, y, new_line, new_frame, frame_count, pwr_ready
    );

    modport slave (
        output enable,
        input  tft_vdd, tft_display, tft_hsync, tft_vsync, tft_data_ena,
        input  x, y, new_line, new_frame, frame_count, pwr_ready
    );
endinterface

// File: rtl/tft_timing_gen.sv
// ---------------------------------------------------------------------------
// tft_timing_gen
// Purpose : parametrised TFT panel timing generator with panel power
//           sequencing. Produces x/y counters, DE, active-low HSYNC/VSYNC,
//           line/frame strobes and a wrapping frame counter.
// Ports   : tft_clk  pixel clock (only clock)
//           rstb     synchronous reset, active high
//           tft      tft_timing_gen_if.master (enable in, all timing out)
// Power sequence: OFF -> VDD_UP (PWR_DLY cycles) -> RUN -> (enable low, end of
//           frame) -> VDD_DN (PWR_DLY cycles) -> OFF.
// ---------------------------------------------------------------------------
module tft_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int PWR_DLY  = 1024,
    parameter int FCNT_W   = 8
) (
    input  logic              tft_clk,
    input  logic              rstb,
    tft_timing_gen_if.master  tft
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DLY_W   = $clog2(PWR_DLY + 1);

    // Sized decode constants. Sync windows use an inclusive last position so
    // that a zero back porch never needs a value of H_TOTAL/V_TOTAL.
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0]   VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PWR_DLY - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_VDD_UP,
        ST_RUN,
        ST_VDD_DN
    } state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              stop_q, stop_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;

    logic              vdd_q, disp_q, rdy_q;
    logic              hsync_q, vsync_q, de_q;
    logic              nl_q, nf_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              run_d;
    logic              de_d, hsync_d, vsync_d, nl_d, nf_d;

    // Next-state and next-position logic.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        stop_d  = stop_q;
        x_d     = '0;
        y_d     = '0;
        unique case (state_q)
            ST_OFF: begin
                stop_d = 1'b0;
                if (tft.enable) begin
                    state_d = ST_VDD_UP;
                    dly_d   = '0;
                end
            end
            ST_VDD_UP: begin
                if (!tft.enable) begin
                    state_d = ST_VDD_DN;
                    dly_d   = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = ST_RUN;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_RUN: begin
                // A stop request is remembered so a brief low on enable
                // still results in a clean shutdown at the end of the frame.
                stop_d = stop_q | ~tft.enable;
                if (stop_d && x_q == X_LAST && y_q == Y_LAST) begin
                    state_d = ST_VDD_DN;
                    dly_d   = '0;
                    stop_d  = 1'b0;
                end else if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                    y_d = y_q;
                end
            end
            ST_VDD_DN: begin
                if (dly_q == DLY_LAST) begin
                    state_d = ST_OFF;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                dly_d   = '0;
            end
        endcase
    end

    // Output decode from the next position so every registered flag lines up
    // with the x/y value registered on the same edge.
    always_comb begin
        run_d   = (state_d == ST_RUN);
        de_d    = run_d && (x_d < X_ACT) && (y_d < Y_ACT);
        hsync_d = !(run_d && (x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d = !(run_d && (y_d >= VS_FIRST) && (y_d <= VS_LAST));
        nl_d    = run_d && (x_d == '0);
        nf_d    = nl_d && (y_d == '0);
        fcnt_d  = fcnt_q;
        // The frame strobe that opens a RUN period marks no completed frame.
        if (nf_d && state_q == ST_RUN) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge tft_clk) begin
        if (rstb) begin
            state_q <= ST_OFF;
            dly_q   <= '0;
            stop_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            vdd_q   <= 1'b0;
            disp_q  <= 1'b0;
            rdy_q   <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            nl_q    <= 1'b0;
            nf_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            stop_q  <= stop_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vdd_q   <= (state_d != ST_OFF);
            disp_q  <= run_d;
            rdy_q   <= run_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            nl_q    <= nl_d;
            nf_q    <= nf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign tft.tft_vdd      = vdd_q;
    assign tft.tft_display  = disp_q;
    assign tft.pwr_ready    = rdy_q;
    assign tft.tft_hsync    = hsync_q;
    assign tft.tft_vsync    = vsync_q;
    assign tft.tft_data_ena = de_q;
    assign tft.x            = x_q;
    assign tft.y            = y_q;
    assign tft.new_line     = nl_q;
    assign tft.new_frame    = nf_q;
    assign tft.frame_count  = fcnt_q;
endmodule
